// File: rtl/cache_arb_pkg.sv
// -----------------------------------------------------------------------------
// cache_arb_pkg
// Shared types and constants for the L1 I/D-cache memory arbiter.
//   arb_state_e   : arbiter FSM states (IDLE, GNT_I, GNT_D)
//   GRANT_I/D     : encoding of the last_grant register (0 = I, 1 = D)
//   *_DEF         : default widths / burst length
//   cmd_bundle_t  : one cache's command bundle at the default widths
//   cnt_width()   : beat counter width for a given burst length
// -----------------------------------------------------------------------------
package cache_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_e;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   localparam int BURST_LEN_DEF = 4;
   localparam int ADDR_W_DEF    = 32;
   localparam int DATA_W_DEF    = 32;
   localparam int TYPE_W_DEF    = 3;

   typedef struct packed {
      logic                  req;
      logic [ADDR_W_DEF-1:0] addr;
      logic                  write;
      logic [DATA_W_DEF-1:0] wdata;
      logic [TYPE_W_DEF-1:0] acc_type;
   } cmd_bundle_t;

   // One extra bit so the counter can hold BURST_LEN itself without wrapping.
   function automatic int cnt_width(input int burst_len);
      return $clog2(burst_len) + 1;
   endfunction

endpackage

// File: rtl/arb_beat_counter.sv
// -----------------------------------------------------------------------------
// arb_beat_counter
// Counts completed memory beats of the granted transaction and flags the beat
// that finishes it: any beat of a write, or beat BURST_LEN-1 of a read.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : zero the count (takes priority over beat)
//   beat       : a beat completes this cycle
//   txn_write  : current transaction is a single-beat write
//   done       : this beat ends the transaction
// -----------------------------------------------------------------------------
module arb_beat_counter
   import cache_arb_pkg::*;
#(
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int CNT_W     = cnt_width(BURST_LEN)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic beat,
   input  logic txn_write,
   output logic done
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;

   // Beat count register: clear dominates increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (beat) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign done = beat & (txn_write | (cnt_r == LAST_BEAT));

endmodule

// File: rtl/l1c_mem_arbiter.sv
// -----------------------------------------------------------------------------
// l1c_mem_arbiter
// Shares one memory-wrapper port between the L1 I-cache and L1 D-cache.
// Whole transactions (BURST_LEN-beat read or single-beat write) are granted
// round-robin; the granted cache's bundle is passed straight through to memory
// and memory wait/data are routed back. The other cache sees wait=1.
// Ports:
//   clk, rst                              : clock, synchronous active-high reset
//   I_req/I_addr/I_write/I_in/I_type      : I-cache command bundle
//   I_out, I_wait                         : read data / wait to I-cache
//   D_req/D_addr/D_write/D_in/D_type      : D-cache command bundle
//   D_out, D_wait                         : read data / wait to D-cache
//   M_req/M_addr/M_write/M_in/M_type      : command to memory wrapper
//   M_out, M_wait                         : read data / wait from memory
// -----------------------------------------------------------------------------
module l1c_mem_arbiter
   import cache_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TYPE_W    = 3,
   parameter int BURST_LEN = BURST_LEN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              I_req,
   input  logic [ADDR_W-1:0] I_addr,
   input  logic              I_write,
   input  logic [DATA_W-1:0] I_in,
   input  logic [TYPE_W-1:0] I_type,
   output logic [DATA_W-1:0] I_out,
   output logic              I_wait,
   input  logic              D_req,
   input  logic [ADDR_W-1:0] D_addr,
   input  logic              D_write,
   input  logic [DATA_W-1:0] D_in,
   input  logic [TYPE_W-1:0] D_type,
   output logic [DATA_W-1:0] D_out,
   output logic              D_wait,
   output logic              M_req,
   output logic [ADDR_W-1:0] M_addr,
   output logic              M_write,
   output logic [DATA_W-1:0] M_in,
   output logic [TYPE_W-1:0] M_type,
   input  logic [DATA_W-1:0] M_out,
   input  logic              M_wait
);

   localparam int CNT_W = cnt_width(BURST_LEN);

   arb_state_e state_r;
   arb_state_e next_state_s;
   logic       last_grant_r;
   logic       txn_write_r;
   logic       beat_s;
   logic       done_s;
   logic       clear_s;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Record the winner and its transaction kind at grant time.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_r <= GRANT_I;
         txn_write_r  <= 1'b0;
      end else if ((state_r == IDLE) && (next_state_s == GNT_I)) begin
         last_grant_r <= GRANT_I;
         txn_write_r  <= I_write;
      end else if ((state_r == IDLE) && (next_state_s == GNT_D)) begin
         last_grant_r <= GRANT_D;
         txn_write_r  <= D_write;
      end else begin
         last_grant_r <= last_grant_r;
         txn_write_r  <= txn_write_r;
      end
   end

   // Next-state: arbitrate in IDLE; leave a grant on completion or when the
   // owner drops its request. Every grant returns through IDLE.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (I_req && D_req) begin
               next_state_s = (last_grant_r == GRANT_I) ? GNT_D : GNT_I;
            end else if (I_req) begin
               next_state_s = GNT_I;
            end else if (D_req) begin
               next_state_s = GNT_D;
            end else begin
               next_state_s = IDLE;
            end
         end
         GNT_I: begin
            if (!I_req || done_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = GNT_I;
            end
         end
         GNT_D: begin
            if (!D_req || done_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = GNT_D;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Command mux and wait routing, purely from state.
   always_comb begin
      M_req   = 1'b0;
      M_addr  = {ADDR_W{1'b0}};
      M_write = 1'b0;
      M_in    = {DATA_W{1'b0}};
      M_type  = {TYPE_W{1'b0}};
      I_wait  = 1'b1;
      D_wait  = 1'b1;
      case (state_r)
         IDLE: begin
            M_req = 1'b0;
         end
         GNT_I: begin
            M_req   = I_req;
            M_addr  = I_addr;
            M_write = I_write;
            M_in    = I_in;
            M_type  = I_type;
            I_wait  = M_wait;
         end
         GNT_D: begin
            M_req   = D_req;
            M_addr  = D_addr;
            M_write = D_write;
            M_in    = D_in;
            M_type  = D_type;
            D_wait  = M_wait;
         end
         default: begin
            M_req = 1'b0;
         end
      endcase
   end

   assign I_out = M_out;
   assign D_out = M_out;

   // M_req already reflects the owner's request, so an aborting cycle or
   // IDLE never counts a beat regardless of M_wait.
   assign beat_s  = M_req & ~M_wait;
   // Hold the count at zero in IDLE and zero it on the way out of a grant.
   assign clear_s = (state_r == IDLE) | (next_state_s == IDLE);

   arb_beat_counter #(
      .BURST_LEN (BURST_LEN),
      .CNT_W     (CNT_W)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_s),
      .beat      (beat_s),
      .txn_write (txn_write_r),
      .done      (done_s)
   );

endmodule
